// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: request kinds, op codes,
// opcode prefixes and rejection codes.
package instr_encoder_pkg;

  localparam int IR_W  = 18;
  localparam int IMM_W = 18;

  typedef enum logic [3:0] {
    KIND_ALU   = 4'd0,
    KIND_SHIFT = 4'd1,
    KIND_JCC   = 4'd2,
    KIND_CALL  = 4'd3,
    KIND_JREG  = 4'd4,
    KIND_MOVI  = 4'd5,
    KIND_SETHI = 4'd6,
    KIND_ADDI  = 4'd7,
    KIND_CMPI  = 4'd8,
    KIND_RDKBD = 4'd9,
    KIND_PUTC  = 4'd10
  } kind_e;

  typedef enum logic [2:0] {
    ALU_AND, ALU_OR, ALU_XOR, ALU_SETHI, ALU_ADD, ALU_SUB, ALU_ADDC, ALU_SUBC
  } alu_op_e;

  // Shift ops occupy two bits; op values 4..7 cannot be encoded and are rejected.
  typedef enum logic [1:0] {
    SH_SLL, SH_SRL, SH_SRA, SH_ROL
  } shift_op_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_KIND     = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_SHIFT_OP = 2'd3
  } err_code_e;

  localparam logic [2:0] PFX_ALU   = 3'b000;
  localparam logic [2:0] PFX_SHIFT = 3'b001;
  localparam logic [2:0] PFX_JCC   = 3'b011;
  localparam logic [2:0] PFX_CALL  = 3'b100;
  localparam logic [2:0] PFX_JREG  = 3'b101;
  localparam logic [4:0] PFX_MOVI  = 5'b11000;
  localparam logic [4:0] PFX_SETHI = 5'b11001;
  localparam logic [4:0] PFX_ADDI  = 5'b11010;
  localparam logic [4:0] PFX_CMPI  = 5'b11011;
  localparam logic [5:0] PFX_RDKBD = 6'b111110;
  localparam logic [5:0] PFX_PUTC  = 6'b111111;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: builds the 18-bit word for one request and
// reports why the request must be rejected, if it must.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  kind_e             kind_i,
  input  logic [2:0]        op_i,
  input  logic              shift_imm_i,
  input  logic [3:0]        rd_i,
  input  logic [3:0]        rs1_i,
  input  logic [3:0]        rs2_i,
  input  logic [3:0]        cond_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [IR_W-1:0]   ir_o,
  output err_code_e         err_o
);

  logic sext9_ok;
  logic abs11_ok;
  logic shamt_ok;

  assign sext9_ok = (imm_i[17:8] == '0) || (imm_i[17:8] == '1);
  assign abs11_ok = (imm_i[17:11] == '0);
  assign shamt_ok = (imm_i[17:4] == '0);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    ir_o  = '0;
    err_o = ERR_NONE;
    case (kind_i)
      KIND_ALU:   ir_o = {PFX_ALU, op_i, rs2_i, rs1_i, rd_i};
      KIND_SHIFT: begin
        ir_o = {PFX_SHIFT, shift_imm_i, op_i[1:0],
                shift_imm_i ? imm_i[3:0] : rs2_i, rs1_i, rd_i};
        if (op_i[2])                       err_o = ERR_SHIFT_OP;
        else if (shift_imm_i && !shamt_ok) err_o = ERR_RANGE;
      end
      KIND_JCC: begin
        ir_o = {PFX_JCC, imm_i[10:0], cond_i};
        if (!abs11_ok) err_o = ERR_RANGE;
      end
      KIND_CALL: begin
        ir_o = {PFX_CALL, imm_i[10:0], rd_i};
        if (!abs11_ok) err_o = ERR_RANGE;
      end
      KIND_JREG: begin
        ir_o = {PFX_JREG, imm_i[10:0], rs1_i};
        if (!abs11_ok) err_o = ERR_RANGE;
      end
      KIND_MOVI: begin
        ir_o = {PFX_MOVI, imm_i[8:0], rd_i};
        if (!sext9_ok) err_o = ERR_RANGE;
      end
      // SETHI carries the upper nine bits; the low bits are simply dropped.
      KIND_SETHI: ir_o = {PFX_SETHI, imm_i[17:9], rd_i};
      KIND_ADDI: begin
        ir_o = {PFX_ADDI, imm_i[8:0], rd_i};
        if (!sext9_ok) err_o = ERR_RANGE;
      end
      KIND_CMPI: begin
        ir_o = {PFX_CMPI, imm_i[8:0], rs1_i};
        if (!sext9_ok) err_o = ERR_RANGE;
      end
      KIND_RDKBD: ir_o = {PFX_RDKBD, 8'h00, rd_i};
      KIND_PUTC:  ir_o = {PFX_PUTC, rs2_i, rs1_i, rd_i};
      default:    err_o = ERR_KIND;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field-level requests, packs them, queues the
// words in a small FIFO and tags each popped word with a program-RAM address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                DEPTH     = 2,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [2:0]        in_op,
  input  logic              in_shift_imm,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [3:0]        in_cond,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IR_W-1:0]   out_ir,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [7:0]        err_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [IR_W-1:0]   pack_ir;
  err_code_e         pack_err;
  logic [IR_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              full, empty, accept, push, pop;

  instr_pack u_pack (
    .kind_i      (kind_e'(in_kind)),
    .op_i        (in_op),
    .shift_imm_i (in_shift_imm),
    .rd_i        (in_rd),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .cond_i      (in_cond),
    .imm_i       (in_imm),
    .ir_o        (pack_ir),
    .err_o       (pack_err)
  );

  assign full      = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !rst && !full;
  assign accept    = in_valid && in_ready;
  // Rejected requests complete the handshake but never enter the FIFO.
  assign push      = accept && (pack_err == ERR_NONE);
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;
  assign out_ir    = empty ? '0 : mem_q[rd_ptr_q];
  assign out_addr  = addr_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

  always_comb begin
    count_d     = count_q;
    addr_d      = addr_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A base load takes priority over the post-pop increment.
    if (load_base)  addr_d = base_addr;
    else if (pop)   addr_d = addr_q + 1'b1;
    if (accept && (pack_err != ERR_NONE)) begin
      err_valid_d = 1'b1;
      err_code_d  = pack_err;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= BASE_ADDR;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  // NOTE: FIFO storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pack_ir;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder with an arithmetic reference encoder,
// a word queue and an address model, plus directed boundary scenarios.
module tb_instr_encoder;

  localparam int         DEPTH  = 2;
  localparam int         ADDR_W = 4;
  localparam logic [3:0] BASE   = 4'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_kind;
  logic [2:0]  in_op;
  logic        in_shift_imm;
  logic [3:0]  in_rd, in_rs1, in_rs2, in_cond;
  logic [17:0] in_imm;
  logic        out_valid, out_ready;
  logic [17:0] out_ir;
  logic [3:0]  out_addr;
  logic        load_base;
  logic [3:0]  base_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  int q[$];
  int exp_addr, exp_err_v, exp_err_code, exp_err_cnt;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_op(in_op), .in_shift_imm(in_shift_imm),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_cond(in_cond),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_addr(out_addr), .load_base(load_base),
    .base_addr(base_addr), .err_valid(err_valid), .err_code(err_code),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: opcode fields placed by weighted sums, ranges by signed value.
  function automatic void ref_encode(input int kind, op, sh, rd, rs1, rs2, cond, imm,
                                     output int ir, output int code);
    int simm;
    simm = (imm >= 131072) ? imm - 262144 : imm;
    ir   = 0;
    code = 0;
    case (kind)
      0: ir = op * 4096 + rs2 * 256 + rs1 * 16 + rd;
      1: begin
        ir = 1 * 32768 + sh * 16384 + (op % 4) * 4096 + (sh ? imm % 16 : rs2) * 256 + rs1 * 16 + rd;
        if (op > 3) code = 3;
        else if (sh && imm > 15) code = 2;
      end
      2: begin ir = 3 * 32768 + (imm % 2048) * 16 + cond; if (imm > 2047) code = 2; end
      3: begin ir = 4 * 32768 + (imm % 2048) * 16 + rd;   if (imm > 2047) code = 2; end
      4: begin ir = 5 * 32768 + (imm % 2048) * 16 + rs1;  if (imm > 2047) code = 2; end
      5: begin ir = 24 * 8192 + (imm % 512) * 16 + rd;  if (simm < -256 || simm > 255) code = 2; end
      6: ir = 25 * 8192 + (imm / 512) * 16 + rd;
      7: begin ir = 26 * 8192 + (imm % 512) * 16 + rd;  if (simm < -256 || simm > 255) code = 2; end
      8: begin ir = 27 * 8192 + (imm % 512) * 16 + rs1; if (simm < -256 || simm > 255) code = 2; end
      9: ir = 62 * 4096 + rd;
      10: ir = 63 * 4096 + rs2 * 256 + rs1 * 16 + rd;
      default: code = 1;
    endcase
  endfunction

  // Advance the model by one clock using the current inputs, then compare at the falling edge.
  task automatic cycle();
    int  ir, code;
    bit  acc, pop;
    if (rst) begin
      q.delete();
      exp_addr = BASE; exp_err_v = 0; exp_err_code = 0; exp_err_cnt = 0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      pop = (q.size() != 0) && out_ready;
      ref_encode(int'(in_kind), int'(in_op), int'(in_shift_imm), int'(in_rd), int'(in_rs1),
                 int'(in_rs2), int'(in_cond), int'(in_imm), ir, code);
      exp_err_v = 0;
      if (pop) void'(q.pop_front());
      if (load_base)  exp_addr = int'(base_addr);
      else if (pop)   exp_addr = (exp_addr + 1) % (1 << ADDR_W);
      if (acc) begin
        if (code != 0) begin
          exp_err_v = 1; exp_err_code = code;
          if (exp_err_cnt < 255) exp_err_cnt++;
        end else q.push_back(ir);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", out_valid, q.size() != 0);
    check("out_ir",    out_ir, (q.size() != 0) ? q[0] : 0);
    check("out_addr",  out_addr, exp_addr);
    check("in_ready",  in_ready, !rst && (q.size() < DEPTH));
    check("err_valid", err_valid, exp_err_v);
    check("err_code",  err_code, exp_err_code);
    check("err_count", err_count, exp_err_cnt);
  endtask

  task automatic req(input int kind, op, sh, rd, rs1, rs2, cond, imm);
    in_valid = 1'b1; in_kind = 4'(kind); in_op = 3'(op); in_shift_imm = 1'(sh);
    in_rd = 4'(rd); in_rs1 = 4'(rs1); in_rs2 = 4'(rs2); in_cond = 4'(cond); in_imm = 18'(imm);
  endtask

  task automatic rand_inputs();
    in_valid     = $urandom_range(0, 3) != 0;
    in_kind      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
    in_op        = 3'($urandom);
    in_shift_imm = 1'($urandom);
    in_rd        = 4'($urandom);
    in_rs1       = 4'($urandom);
    in_rs2       = 4'($urandom);
    in_cond      = 4'($urandom);
    case ($urandom_range(0, 3))
      0:       in_imm = 18'($urandom);
      1:       in_imm = 18'(int'($urandom_range(0, 600)) - 300);
      2:       in_imm = 18'($urandom_range(0, 2100));
      default: in_imm = 18'($urandom_range(0, 20));
    endcase
    out_ready = $urandom_range(0, 2) != 0;
    load_base = $urandom_range(0, 19) == 0;
    base_addr = 4'($urandom);
    rst       = $urandom_range(0, 299) == 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_kind = '0; in_op = '0; in_shift_imm = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_cond = '0; in_imm = '0;
    out_ready = 1'b0; load_base = 1'b0; base_addr = '0;
    @(negedge clk);
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ir", out_ir, 0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_err_count", err_count, 0);
    rst = 1'b0; #1;
    check("rst_rel_in_ready", in_ready, 1);

    // ALU ADD then MOVI -1 fill the FIFO while the consumer stalls.
    req(0, 4, 0, 1, 2, 3, 0, 0);
    cycle();
    check("alu_add_ir", out_ir, 18'h04321);
    check("alu_add_addr", out_addr, BASE);
    req(5, 0, 0, 5, 0, 0, 0, 18'h3FFFF);
    cycle();
    check("full_in_ready", in_ready, 0);
    req(7, 0, 0, 2, 0, 0, 0, 256);
    cycle();
    check("full_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    cycle();
    check("movi_ir", out_ir, 18'h31FF5);
    check("movi_addr", out_addr, BASE + 1);
    cycle();
    check("addi_err_valid", err_valid, 1);
    check("addi_err_code", err_code, 2);
    check("addi_no_word", out_valid, 0);

    // JCC at the top of its range, then an illegal kind.
    out_ready = 1'b0;
    req(2, 0, 0, 0, 0, 0, 4'hE, 18'h007FF);
    cycle();
    check("jcc_ir", out_ir, 18'h1FFFE);
    req(12, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    check("kind12_err_code", err_code, 1);
    check("kind12_err_count", err_count, 2);
    check("kind12_in_ready", in_ready, 1);

    // Base load during a pop: the popped word keeps its address, counter takes the base.
    in_valid = 1'b0; out_ready = 1'b1; load_base = 1'b1; base_addr = 4'd15;
    check("pop_old_addr", out_addr, BASE + 2);
    cycle();
    check("load_addr", out_addr, 15);
    load_base = 1'b0;
    req(0, 1, 0, 7, 8, 9, 0, 0);
    cycle();
    check("wrap_first_addr", out_addr, 15);
    req(10, 0, 0, 1, 2, 3, 0, 0);
    cycle();
    check("wrap_second_addr", out_addr, 0);
    in_valid = 1'b0;
    cycle();

    // Reset with two words queued.
    out_ready = 1'b0;
    req(9, 0, 0, 4, 0, 0, 0, 0);
    cycle();
    cycle();
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_addr", out_addr, BASE);
    rst = 1'b0; #1;
    check("midrst_in_ready", in_ready, 1);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    // Error counter saturation.
    rst = 1'b0; load_base = 1'b0; out_ready = 1'b1;
    req(15, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) cycle();
    check("err_count_sat", err_count, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
